// File: rtl/ram_loader.sv
// ============================================================================
// Module   : ram_loader
// Function : Streams DEPTH bytes over valid/ready into RAM via MAR/RAM strobes,
//            with optional read-back verification of every written byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ram_value,
  output logic [ADDR_W-1:0] mar_bus,
  output logic              mi,
  output logic [DATA_W-1:0] ram_bus,
  output logic              ri,
  output logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_wait    = 3'd1;
  localparam logic [2:0] c_setaddr = 3'd2;
  localparam logic [2:0] c_write   = 3'd3;
  localparam logic [2:0] c_check   = 3'd4;

  localparam logic [ADDR_W-1:0] c_last   = ADDR_W'(DEPTH - 1);
  localparam logic              c_verify = (VERIFY != 0);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic              w_accept;
  logic              w_byte_end;

  assign w_accept   = (r_state == c_wait) && in_valid;
  assign w_byte_end = ((r_state == c_write) && !c_verify) || (r_state == c_check);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= c_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:    if (start) w_next = c_wait;
      c_wait:    if (in_valid) w_next = c_setaddr;
      c_setaddr: w_next = c_write;
      c_write:   if (c_verify) w_next = c_check;
                 else          w_next = (r_cnt == c_last) ? c_idle : c_wait;
      c_check:   w_next = (r_cnt == c_last) ? c_idle : c_wait;
      default:   w_next = c_idle;
    endcase
  end

  // The address is latched into r_mar at accept time so it is stable in SETADDR
  // and keeps showing the last driven address afterwards.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt      <= '0;
      r_mar      <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_done <= w_byte_end && (r_cnt == c_last);
      if ((r_state == c_idle) && start) begin
        r_cnt      <= '0;
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end
      if (w_accept) begin
        r_data <= in_data;
        r_mar  <= r_cnt;
      end
      if ((r_state == c_check) && (ram_value != r_data) && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= r_cnt;
      end
      if (w_byte_end) r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    mi       = 1'b0;
    ri       = 1'b0;
    busy     = 1'b0;
    hold     = 1'b0;
    case (r_state)
      c_wait:    in_ready = 1'b1;
      c_setaddr: mi       = 1'b1;
      c_write:   ri       = 1'b1;
      default:   ;
    endcase
    if (r_state != c_idle) begin
      busy = 1'b1;
      hold = 1'b1;
    end
  end

  assign mar_bus  = r_mar;
  assign ram_bus  = r_data;
  assign done     = r_done;
  assign err      = r_err;
  assign err_addr = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// ============================================================================
// Module   : tb_ram_loader
// Function : Directed self-checking bench for ram_loader with a 16x8 RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] ram_value;
  logic [3:0] mar_bus;
  logic       mi;
  logic [7:0] ram_bus;
  logic       ri;
  logic       hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] err_addr;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [16];
  logic [3:0] mar = 4'd0;
  logic       corrupt = 1'b0;
  logic [3:0] mar_log [32];
  int         n_mi;

  always #5 clk = ~clk;

  ram_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .VERIFY(1)) dut (
    .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_value(ram_value), .mar_bus(mar_bus), .mi(mi),
    .ram_bus(ram_bus), .ri(ri), .hold(hold), .busy(busy), .done(done),
    .err(err), .err_addr(err_addr)
  );

  always @(posedge clk) begin
    if (mi) mar <= mar_bus;
    if (ri) mem[mar] <= ram_bus;
  end

  assign ram_value = mem[mar] ^ ((corrupt && (mar == 4'd6 || mar == 4'd9)) ? 8'hFF : 8'h00);

  function automatic logic [27:0] outs();
    return {in_ready, mi, ri, hold, busy, done, err, mar_bus, ram_bus, err_addr, 2'b00};
  endfunction

  // Drives one load run; reports timing/strobe observations for the caller to judge.
  task automatic run_load(input logic [7:0] base, input int stall_byte, input int stall_len,
                          input int pulse_byte, input int abort_addr,
                          output int span, output int ndone, output bit strobe_bad,
                          output bit stall_bad, output bit err_first, output bit aborted);
    int idx, stall_left, first_rdy, done_cyc;
    bit prev_mi, pulsed;
    idx = 0; ndone = 0; strobe_bad = 0; stall_bad = 0; err_first = 1; aborted = 0;
    first_rdy = -1; done_cyc = -1; prev_mi = 0; pulsed = 0; stall_left = stall_len;
    n_mi = 0; span = -1;
    @(negedge clk); start = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (in_ready && first_rdy < 0) begin first_rdy = cyc; err_first = err; end
      if (done) begin ndone++; done_cyc = cyc; end
      if (mi && ri) strobe_bad = 1;
      if (ri && !prev_mi) strobe_bad = 1;
      if (mi && n_mi < 32) begin mar_log[n_mi] = mar_bus; n_mi++; end
      prev_mi = mi;
      if (abort_addr >= 0 && ri && mar_bus == 4'(abort_addr)) begin
        clr = 1'b1; in_valid = 1'b0; aborted = 1; return;
      end
      in_data = base + 8'(idx);
      if (idx == stall_byte && in_ready && stall_left > 0) begin
        in_valid = 1'b0; stall_left--;
      end else begin
        if (idx == stall_byte && stall_left < stall_len && stall_left > 0 && !in_ready) stall_bad = 1;
        in_valid = (idx < 16);
      end
      if (idx == pulse_byte && in_ready && !pulsed) begin start = 1'b1; pulsed = 1; end
      if (in_ready && in_valid) idx++;
      if (ndone > 0 && cyc > done_cyc + 4) break;
    end
    in_valid = 1'b0;
    if (ndone > 0) span = done_cyc - first_rdy;
  endtask

  task automatic test_reset();
    bit bad = 0;
    clr = 1'b1; @(negedge clk); @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (outs() !== 28'd0) bad = 1;
    end
    vectors++;
    if (bad) begin errors++; $display("FAIL reset_idle: outputs %h, required all zero", outs()); end
  endtask

  task automatic test_full_load();
    int span, nd; bit sb, stb, ef, ab, membad, seqbad;
    run_load(8'h10, -1, 0, -1, -1, span, nd, sb, stb, ef, ab);
    vectors++;
    if (span !== 64) begin errors++; $display("FAIL full_span: got %0d, required 64", span); end
    vectors++;
    if (nd !== 1) begin errors++; $display("FAIL full_done_count: got %0d, required 1", nd); end
    vectors++;
    if (sb) begin errors++; $display("FAIL full_strobes: mi/ri order bad=%0d, required 0", sb); end
    membad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 8'h10 + 8'(i)) membad = 1;
    vectors++;
    if (membad) begin errors++; $display("FAIL full_ram: mem[0]=%h mem[15]=%h, required 10..1f", mem[0], mem[15]); end
    seqbad = (n_mi != 16);
    for (int i = 0; i < 16 && i < n_mi; i++) if (mar_log[i] !== 4'(i)) seqbad = 1;
    vectors++;
    if (seqbad) begin errors++; $display("FAIL full_addr_seq: n_mi=%0d, required 16 in order", n_mi); end
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0 || hold !== 1'b0) begin
      errors++; $display("FAIL full_end_state: err=%b busy=%b hold=%b, required 0 0 0", err, busy, hold);
    end
  endtask

  task automatic test_backpressure();
    int span, nd; bit sb, stb, ef, ab;
    run_load(8'h40, 3, 5, -1, -1, span, nd, sb, stb, ef, ab);
    vectors++;
    if (span !== 69) begin errors++; $display("FAIL bp_span: got %0d, required 69", span); end
    vectors++;
    if (stb) begin errors++; $display("FAIL bp_in_ready: in_ready dropped during stall, required 1"); end
    vectors++;
    if (mem[3] !== 8'h43 || mem[4] !== 8'h44) begin
      errors++; $display("FAIL bp_byte3: mem[3]=%h mem[4]=%h, required 43 44", mem[3], mem[4]);
    end
  endtask

  task automatic test_verify_fail();
    int span, nd; bit sb, stb, ef, ab;
    corrupt = 1'b1;
    run_load(8'h80, -1, 0, -1, -1, span, nd, sb, stb, ef, ab);
    corrupt = 1'b0;
    vectors++;
    if (err !== 1'b1) begin errors++; $display("FAIL vf_err: got %b, required 1", err); end
    vectors++;
    if (err_addr !== 4'd6) begin errors++; $display("FAIL vf_err_addr: got %0d, required 6", err_addr); end
    vectors++;
    if (nd !== 1 || span !== 64) begin errors++; $display("FAIL vf_done: done=%0d span=%0d, required 1 64", nd, span); end
    run_load(8'h90, -1, 0, -1, -1, span, nd, sb, stb, ef, ab);
    vectors++;
    if (ef !== 1'b0) begin errors++; $display("FAIL vf_err_clear: err at first in_ready=%b, required 0", ef); end
    vectors++;
    if (err !== 1'b0) begin errors++; $display("FAIL vf_clean_run: err=%b, required 0", err); end
  endtask

  task automatic test_reset_mid_run();
    int span, nd; bit sb, stb, ef, ab, membad;
    run_load(8'hA0, -1, 0, -1, 5, span, nd, sb, stb, ef, ab);
    #1;
    vectors++;
    if (!ab || outs() !== 28'd0) begin
      errors++; $display("FAIL mid_reset_outs: aborted=%b outs=%h, required 1 and all zero", ab, outs());
    end
    @(negedge clk); clr = 1'b0;
    membad = 0;
    for (int i = 0; i < 5; i++) if (mem[i] !== 8'hA0 + 8'(i)) membad = 1;
    vectors++;
    if (membad) begin errors++; $display("FAIL mid_reset_keep: mem[0]=%h mem[4]=%h, required a0 a4", mem[0], mem[4]); end
    run_load(8'hC0, -1, 0, -1, -1, span, nd, sb, stb, ef, ab);
    vectors++;
    if (nd !== 1 || mar_log[0] !== 4'd0 || mem[0] !== 8'hC0 || mem[15] !== 8'hCF) begin
      errors++; $display("FAIL mid_reset_reload: done=%0d addr0=%0d mem0=%h mem15=%h, required 1 0 c0 cf",
                         nd, mar_log[0], mem[0], mem[15]);
    end
  endtask

  task automatic test_start_while_busy();
    int span, nd; bit sb, stb, ef, ab, seqbad;
    run_load(8'h20, -1, 0, 8, -1, span, nd, sb, stb, ef, ab);
    seqbad = (n_mi != 16);
    for (int i = 0; i < 16 && i < n_mi; i++) if (mar_log[i] !== 4'(i)) seqbad = 1;
    vectors++;
    if (seqbad) begin errors++; $display("FAIL busy_start_seq: n_mi=%0d, required 16 in order", n_mi); end
    vectors++;
    if (nd !== 1 || span !== 64) begin errors++; $display("FAIL busy_start_done: done=%0d span=%0d, required 1 64", nd, span); end
    vectors++;
    if (mem[8] !== 8'h28 || mem[15] !== 8'h2F) begin
      errors++; $display("FAIL busy_start_ram: mem[8]=%h mem[15]=%h, required 28 2f", mem[8], mem[15]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_full_load();
    test_backpressure();
    test_verify_fail();
    test_reset_mid_run();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Program-load sequencer directly upstream of the 16x8 RAM/MAR stage.
- Accepts a byte stream over a valid/ready handshake and writes it into RAM addresses 0..DEPTH-1 in order.
- Drives the RAM's MAR-load (mi) and RAM-write (ri) strobes, and optionally reads each location back to verify it.
- Holds the CPU off the bus while loading.

Parameters:
- DEPTH, 16, number of RAM locations loaded per run.
- ADDR_W, 4, address width (DEPTH = 2**ADDR_W).
- DATA_W, 8, data width.
- VERIFY, 1, 1 = read back and compare each byte after writing it; 0 = no read-back.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- clr, input, 1, asynchronous active-high reset.
- start, input, 1, pulse that begins a load run; ignored while busy.
- in_data, input, DATA_W, byte to be written.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, loader accepts a byte this cycle.
- ram_value, input, DATA_W, RAM read data, combinational ram[mar].
- mar_bus, output, ADDR_W, address presented to the MAR.
- mi, output, 1, MAR load strobe.
- ram_bus, output, DATA_W, write data presented to the RAM.
- ri, output, 1, RAM write strobe.
- hold, output, 1, CPU control/clock gating request.
- busy, output, 1, a load run is in progress.
- done, output, 1, one-cycle pulse when a run completes.
- err, output, 1, sticky verify-mismatch flag.
- err_addr, output, ADDR_W, address of the first mismatch.

Behaviour:
- Interface timing:
  - One clock; clr is asynchronous, active-high.
  - Every output is decoded from or held in registers only, with no combinational path from inputs.
- Reset (clr=1, at any time including mid-run):
  - State returns to IDLE.
  - mar_bus=0, ram_bus=0, mi=0, ri=0, in_ready=0, busy=0, hold=0, done=0, err=0, err_addr=0, address counter=0.
  - RAM contents already written are not rolled back.
- States: IDLE, WAIT, SETADDR, WRITE, CHECK.
- IDLE:
  - start=1 → WAIT; address counter=0; err and err_addr cleared.
  - busy=1 and hold=1 from the next cycle.
- WAIT:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data into the data register, then → SETADDR.
  - in_valid is ignored in all other states; the source must hold data until accepted.
- SETADDR:
  - mi=1; mar_bus=counter; ram_bus=captured data.
  - → WRITE. The MAR holds counter after this edge.
- WRITE:
  - ri=1; ram_bus=captured data.
  - RAM location mar is written at this edge.
  - VERIFY=1 → CHECK; VERIFY=0 → end-of-byte step.
- CHECK:
  - Compare ram_value with the captured data.
  - On mismatch with err=0: set err=1 and err_addr=counter.
  - Later mismatches leave err_addr unchanged; the run continues.
  - Then end-of-byte step.
- End-of-byte step:
  - counter==DEPTH-1 → IDLE, done=1 for exactly one cycle, busy and hold drop in that same cycle, counter wraps to 0.
  - Otherwise counter+1 → WAIT.
- Throughput:
  - 4 cycles per byte (VERIFY=1) or 3 (VERIFY=0), plus any WAIT stall.
  - First byte: in_ready rises 1 cycle after start.
- Strobes:
  - mi and ri are never asserted in the same cycle.
  - Neither is asserted outside SETADDR/WRITE.
- start while busy: no effect.
- start and clr together: clr wins.
- ram_bus: holds the last captured byte between writes.
- mar_bus: holds the last driven address.

Test Plan:
- Reset then idle: clr pulse, no start → all outputs 0 for 20 cycles; mi and ri never high.
- Full load: start, stream bytes 0x10..0x1F with in_valid always 1 → RAM[i]=0x10+i for i=0..15. Per byte, mi then ri in consecutive cycles. done pulses once 64 cycles after the first in_ready. err=0.
- Backpressure: deassert in_valid for 5 cycles before byte 3 → loader stays in WAIT with in_ready=1. Byte 3 lands at address 3 and the total run lengthens by exactly 5 cycles.
- Verify fail: force ram_value mismatch at addresses 6 and 9 → err=1, err_addr=6. Run still completes with done. A new start clears err.
- Reset mid-run: assert clr during WRITE of address 5 → all outputs return to reset values immediately. Addresses 0..4 keep their data. A new start reloads from address 0.
- start while busy: pulse start at byte 8 → no restart; counter sequence continues 8..15; exactly one done pulse.
